lms_coef_update_p: RTL and testbench

LMS_COEF_UPDATE_P -- requirements
Module: lms_coef_update_p

---
 rtl/lms_coef_update_p.sv | 109 ++++++++++
 tb/tb_lms_coef_update_p.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lms_coef_update_p.sv
// ---------------------------------------------------------------------------
// lms_coef_update_p : two-stage pipelined LMS coefficient update (tap line,
// mu*err*x products, saturating accumulate). Define LMS_LEAK_EN for leakage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lms_coef_update_p #(
  parameter int TAPS    = 9,
  parameter int DW      = 16,
  parameter int MUW     = 16,
  parameter int CW      = 16,
  parameter int SHIFT   = 2,
  parameter int LEAK_SH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic signed [DW-1:0] data_i,
  input  logic                 data_vld_i,
  input  logic signed [DW-1:0] err_i,
  input  logic                 err_vld_i,
  input  logic signed [MUW-1:0] mu_i,
  input  logic                 update_en_i,
  input  logic                 clr_i,
  output logic [TAPS*CW-1:0]   coef_o,
  output logic                 coef_vld_o,
  output logic                 sat_o
);

  localparam int PW = 2*DW + MUW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(SW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] COEF_MAX = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [CW-1:0] COEF_MIN = {1'b1, {(CW-1){1'b0}}};

  if (TAPS < 2 || TAPS > 32 || LEAK_SH < 1 || LEAK_SH >= CW) begin : g_param_check
    $error("lms_coef_update_p: illegal TAPS or LEAK_SH");
  end

  logic signed [DW-1:0] taps [TAPS];
  logic signed [PW-1:0] prod [TAPS];
  logic signed [PW-1:0] pk   [TAPS];
  logic signed [CW-1:0] coef [TAPS];
  logic signed [SW-1:0] sum  [TAPS];
  logic signed [CW-1:0] next [TAPS];
  logic [TAPS-1:0]      clip;
  logic                 p_vld;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign prod[k] = (PW'(mu_i) * PW'(err_i) * PW'(taps[k])) >>> SHIFT;
`ifdef LMS_LEAK_EN
    assign sum[k]  = SW'(coef[k]) - SW'(coef[k] >>> LEAK_SH) + SW'(pk[k]);
`else
    assign sum[k]  = SW'(coef[k]) + SW'(pk[k]);
`endif
    // the wide sum cannot wrap, so a plain compare against the CW limits suffices
    assign clip[k] = (sum[k] > SUM_MAX) || (sum[k] < SUM_MIN);
    assign next[k] = (sum[k] > SUM_MAX) ? COEF_MAX :
                     (sum[k] < SUM_MIN) ? COEF_MIN : sum[k][CW-1:0];
    assign coef_o[k*CW +: CW] = coef[k];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else if (data_vld_i) begin
      taps[0] <= data_i;
      for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
    end
  end

  // stage 1 samples the pre-shift taps when data and error strobe together
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < TAPS; k++) pk[k] <= '0;
      p_vld <= 1'b0;
    end else if (clr_i) begin
      for (int k = 0; k < TAPS; k++) pk[k] <= '0;
      p_vld <= 1'b0;
    end else if (err_vld_i && update_en_i) begin
      for (int k = 0; k < TAPS; k++) pk[k] <= prod[k];
      p_vld <= 1'b1;
    end else begin
      p_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      coef_vld_o <= 1'b0;
      sat_o      <= 1'b0;
    end else if (clr_i) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      coef_vld_o <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      coef_vld_o <= p_vld;
      if (p_vld) begin
        for (int k = 0; k < TAPS; k++) coef[k] <= next[k];
        if (|clip) sat_o <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lms_coef_update_p.sv
// Scoreboard bench for lms_coef_update_p: directed scenarios plus random traffic
// against an arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_lms_coef_update_p;
  localparam int TAPS = 9, DW = 16, MUW = 16, CW = 16, SHIFT = 2, LEAK_SH = 8;
  localparam longint CMAX = (longint'(1) << (CW-1)) - 1;
  localparam longint CMIN = -(longint'(1) << (CW-1));

  logic clk = 1'b0, rst_n = 1'b0;
  logic signed [DW-1:0]  data = '0, err = '0;
  logic signed [MUW-1:0] mu = '0;
  logic data_vld = 1'b0, err_vld = 1'b0, update_en = 1'b0, clr = 1'b0;
  logic [TAPS*CW-1:0] coef;
  logic coef_vld, sat;

  lms_coef_update_p #(.TAPS(TAPS), .DW(DW), .MUW(MUW), .CW(CW), .SHIFT(SHIFT),
                      .LEAK_SH(LEAK_SH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(data), .data_vld_i(data_vld),
    .err_i(err), .err_vld_i(err_vld), .mu_i(mu), .update_en_i(update_en),
    .clr_i(clr), .coef_o(coef), .coef_vld_o(coef_vld), .sat_o(sat));

  always #5 clk = ~clk;

  typedef struct { logic [TAPS*CW-1:0] coef; logic sat; int cyc; } exp_t;
  exp_t   sbq[$];
  longint xm[TAPS];
  longint mc[TAPS];
  bit     msat;
  int     cyc = 0, compared = 0, mismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin xm[k] = 0; mc[k] = 0; end
    msat = 0;
  endtask

  // one clock of stimulus; the model sees the same inputs the DUT captures next edge
  task automatic drive(input bit dv, input longint d, input bit ev, input longint e,
                       input longint m, input bit en, input bit c);
    exp_t   x;
    longint p, s;
    data_vld = dv; data = DW'(d); err_vld = ev; err = DW'(e); mu = MUW'(m);
    update_en = en; clr = c;
    if (c) begin
      while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
      for (int k = 0; k < TAPS; k++) mc[k] = 0;
      msat = 0;
    end else if (ev && en) begin
      for (int k = 0; k < TAPS; k++) begin
        p = (m * e * xm[k]) >>> SHIFT;
`ifdef LMS_LEAK_EN
        s = mc[k] - (mc[k] >>> LEAK_SH) + p;
`else
        s = mc[k] + p;
`endif
        if (s > CMAX) begin s = CMAX; msat = 1; end
        else if (s < CMIN) begin s = CMIN; msat = 1; end
        mc[k] = s;
        x.coef[k*CW +: CW] = mc[k][CW-1:0];
      end
      x.sat = msat;
      x.cyc = cyc + 2;
      sbq.push_back(x);
    end
    if (dv) begin
      for (int k = TAPS-1; k > 0; k--) xm[k] = xm[k-1];
      xm[0] = d;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_all(input string nm, input longint req);
    for (int k = 0; k < TAPS; k++)
      chk(nm, longint'($signed(coef[k*CW +: CW])), req);
  endtask

  // monitor: every coef_vld pulse must match the oldest outstanding update
  always @(negedge clk) begin
    if (rst_n) begin
      if (coef_vld) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse: got coef_vld=1, expected none (cyc %0d)", cyc);
        end else begin
          exp_t x;
          x = sbq.pop_front();
          if (coef !== x.coef || sat !== x.sat || cyc != x.cyc) begin
            mismatched++;
            $display("FAIL update: got coef=%h sat=%b cyc=%0d, expected coef=%h sat=%b cyc=%0d",
                     coef, sat, cyc, x.coef, x.sat, x.cyc);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missing_pulse: got no coef_vld, expected one at cyc %0d", sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    longint d, e, m;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    chk_all("reset_coef", 0);
    chk("reset_vld", longint'(coef_vld), 0);
    chk("reset_sat", longint'(sat), 0);

    repeat (TAPS) drive(1, 100, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 4, 1, 1, 0);
    idle(3);
    chk_all("single_update", 100);

    repeat (400) drive(0, 0, 1, 4, 1, 1, 0);
    idle(3);
    chk_all("saturated", CMAX);
    chk("sat_set", longint'(sat), 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk_all("clr_coef", 0);
    chk("clr_sat", longint'(sat), 0);

    drive(0, 0, 1, 4, 1, 1, 0);
    repeat (5) drive(0, 0, 1, 4, 1, 0, 0);
    idle(3);
    chk_all("freeze_inflight", 100);
    chk("freeze_vld", longint'(coef_vld), 0);

    drive(0, 0, 0, 0, 0, 1, 1);
    drive(1, 5, 0, 0, 0, 1, 0);
    drive(1, 7, 1, 4, 1, 1, 0);
    idle(3);
    chk("same_cycle_c0", longint'($signed(coef[0 +: CW])), 5);
    chk("same_cycle_c1", longint'($signed(coef[CW +: CW])), 100);

`ifdef LMS_LEAK_EN
    drive(0, 0, 0, 0, 0, 1, 1);
    repeat (TAPS) drive(1, 256, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 4, 1, 1, 0);
    repeat (TAPS) drive(1, 100, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 4, 1, 1, 0);
    idle(3);
    chk_all("leak_update", 355);
`endif

    // reset while an update sits in stage 1
    drive(0, 0, 1, 4, 1, 1, 0);
    rst_n = 1'b0;
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    chk_all("reset_midflight", 0);
    chk("reset_midflight_sat", longint'(sat), 0);

    repeat (1500) begin
      if ($urandom_range(0, 9) == 0) d = longint'(int'($urandom_range(0, 65535))) - 32768;
      else d = longint'(int'($urandom_range(0, 200))) - 100;
      e = longint'(int'($urandom_range(0, 128))) - 64;
      m = longint'(int'($urandom_range(0, 6))) - 2;
      drive(bit'($urandom_range(0, 1)), d, $urandom_range(0, 2) == 0, e, m,
            $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    idle(4);
    chk("drained", longint'(sbq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
